pmod_led_ctrl: RTL and testbench

Sequencer for the board's two active-low pmod push-buttons and three user LEDs. It synchronises and debounces both buttons and turns debounced presses into one-cycle events. A run/pause/idle state machine uses those events to drive a free-running 3-bit LED counter. It replaces direct combinational button-to-LED wiring in the top level.

---
 rtl/pmod_led_ctrl.sv | 148 ++++++++++++++
 tb/tb_pmod_led_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pmod_led_ctrl.sv
// Button sequencer: synchronises and debounces two active-low pmod buttons and
// runs a run/pause/idle state machine that steps a 3-bit LED counter.
module pmod_led_ctrl #(
  parameter int DEB_CYCLES  = 120000,
  parameter int TICK_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pmod,
  output logic [2:0] led,
  output logic [1:0] state,
  output logic       dir
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    deb_p2;
  logic [DW-1:0] deb_cnt_p2 [2];
  logic [1:0]    press;

  state_t        state_q, state_nxt;
  logic [TW-1:0] tick_q, tick_nxt;
  logic [2:0]    count_q, count_nxt;
  logic          dir_q, dir_nxt;
  logic [2:0]    led_q, led_nxt;

  function automatic logic [2:0] step_count(input logic [2:0] c, input logic down);
    return down ? (c - 3'd1) : (c + 3'd1);
  endfunction

  // Stage p0/p1: two-flop synchroniser, idles at the released (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= pmod;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-bit debounce; any sample matching deb restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_p2 <= 2'b11;
      for (int i = 0; i < 2; i++) deb_cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt_p2[i] <= '0;
        end else if (deb_cnt_p2[i] == DEB_LAST) begin
          deb_p2[i]     <= sync_p1[i];
          deb_cnt_p2[i] <= '0;
        end else begin
          deb_cnt_p2[i] <= deb_cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  // Press fires on the same edge the debounced level falls
  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++)
      press[i] = (sync_p1[i] != deb_p2[i]) && (deb_cnt_p2[i] == DEB_LAST) && !sync_p1[i];
  end

  always_comb begin
    state_nxt = state_q;
    tick_nxt  = tick_q;
    count_nxt = count_q;
    dir_nxt   = dir_q;
    case (state_q)
      IDLE: begin
        if (press[1]) begin
          dir_nxt = ~dir_q;
        end else if (press[0]) begin
          state_nxt = RUN;
          tick_nxt  = '0;
          count_nxt = 3'd0;
        end
      end
      RUN: begin
        // A wrap on the pausing edge still steps; a stop discards it below
        if (tick_q == TICK_LAST) begin
          tick_nxt  = '0;
          count_nxt = step_count(count_q, dir_q);
        end else begin
          tick_nxt = tick_q + 1'b1;
        end
        if (press[1]) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          count_nxt = 3'd0;
        end else if (press[0]) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (press[1]) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          count_nxt = 3'd0;
        end else if (press[0]) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        count_nxt = 3'd0;
      end
    endcase
    led_nxt = (state_nxt == IDLE) ? 3'b000 : count_nxt;
  end

  // Stage p3: registered FSM state and LED outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      count_q <= 3'd0;
      dir_q   <= 1'b0;
      led_q   <= 3'b000;
    end else begin
      state_q <= state_nxt;
      tick_q  <= tick_nxt;
      count_q <= count_nxt;
      dir_q   <= dir_nxt;
      led_q   <= led_nxt;
    end
  end

  assign led   = led_q;
  assign state = state_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_pmod_led_ctrl.sv
// Directed bench for pmod_led_ctrl with DEB_CYCLES=4, TICK_CYCLES=8: a vector
// table for the main scenario plus hand sequences for multi-cycle corners.
module tb_pmod_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pmod;
  logic [2:0] led;
  logic [1:0] state;
  logic       dir;

  int n_cmp = 0;
  int n_bad = 0;

  pmod_led_ctrl #(.DEB_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .pmod  (pmod),
    .led   (led),
    .state (state),
    .dir   (dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] pmod;
    int         cycles;
    logic [1:0] st;
    logic [2:0] led;
    logic       dir;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] p, input int n,
                     input logic [1:0] s, input logic [2:0] l, input logic d,
                     input string nm);
    vec_t v;
    v.rst = r; v.pmod = p; v.cycles = n; v.st = s; v.led = l; v.dir = d; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] s, input logic [2:0] l, input logic d);
    n_cmp++;
    if ({state, led, dir} !== {s, l, d}) begin
      n_bad++;
      $display("FAIL %s: got state=%b led=%b dir=%b, want state=%b led=%b dir=%b",
               nm, state, led, dir, s, l, d);
    end
  endtask

  initial begin
    rst  = 1'b1;
    pmod = 2'b11;

    // Edge counts are relative to the previous row; E = RUN entry edge
    add(1, 2'b11,   2, 2'b00, 3'b000, 0, "reset");
    add(0, 2'b10,   5, 2'b00, 3'b000, 0, "before_6th_edge");
    add(0, 2'b10,   1, 2'b01, 3'b000, 0, "start_on_6th_edge");      // E
    add(0, 2'b10,   7, 2'b01, 3'b000, 0, "no_step_at_E+7");
    add(0, 2'b10,   1, 2'b01, 3'b001, 0, "first_step_E+8");
    add(0, 2'b10,   6, 2'b01, 3'b001, 0, "held_20_one_transition");  // E+14
    add(0, 2'b11,   2, 2'b01, 3'b010, 0, "step_E+16");
    add(0, 2'b11,   8, 2'b01, 3'b011, 0, "release_no_event");        // E+24
    add(0, 2'b11,  32, 2'b01, 3'b111, 0, "count_7_E+56");
    add(0, 2'b11,   8, 2'b01, 3'b000, 0, "wrap_7_to_0_E+64");
    add(0, 2'b11,  20, 2'b01, 3'b010, 0, "count_2_E+84");
    add(0, 2'b10,   5, 2'b01, 3'b011, 0, "count_3_E+89");
    add(0, 2'b10,   1, 2'b10, 3'b011, 0, "pause_at_3");              // E+90, tick frozen at 2
    add(0, 2'b11, 100, 2'b10, 3'b011, 0, "pause_hold_100");
    add(0, 2'b10,   6, 2'b01, 3'b011, 0, "resume");                  // P
    add(0, 2'b10,   5, 2'b01, 3'b011, 0, "resume_no_step_P+5");
    add(0, 2'b10,   1, 2'b01, 3'b100, 0, "resume_step_P+6");
    add(0, 2'b01,   6, 2'b00, 3'b000, 0, "stop_from_run");
    add(0, 2'b11,   8, 2'b00, 3'b000, 0, "idle_settle");
    add(0, 2'b01,   6, 2'b00, 3'b000, 1, "dir_toggle_idle");
    add(0, 2'b11,   8, 2'b00, 3'b000, 1, "dir_settle");
    add(0, 2'b10,   6, 2'b01, 3'b000, 1, "start_down");              // E2
    add(0, 2'b11,   8, 2'b01, 3'b111, 1, "down_first_step_111");
    add(0, 2'b01,   6, 2'b00, 3'b000, 1, "stop_keeps_dir");
    add(0, 2'b11,   8, 2'b00, 3'b000, 1, "stop_settle");
    add(0, 2'b00,   6, 2'b00, 3'b000, 0, "simultaneous_press");
    add(0, 2'b11,   8, 2'b00, 3'b000, 0, "simul_settle");
    add(0, 2'b10,   6, 2'b01, 3'b000, 0, "start_again");             // E3
    add(0, 2'b11,  40, 2'b01, 3'b101, 0, "count_5_E3+40");
    add(1, 2'b11,   1, 2'b00, 3'b000, 0, "reset_mid_run");
    add(0, 2'b11,   9, 2'b00, 3'b000, 0, "idle_after_reset");

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      pmod = vecs[i].pmod;
      run(vecs[i].cycles);
      check(vecs[i].name, vecs[i].st, vecs[i].led, vecs[i].dir);
    end

    // Glitch: three low samples never satisfy the four-cycle debounce
    pmod = 2'b10;
    run(3);
    pmod = 2'b11;
    for (int k = 0; k < 10; k++) begin
      run(1);
      check("glitch_rejected", 2'b00, 3'b000, 1'b0);
    end

    // Button held through reset yields exactly one press afterwards
    rst  = 1'b1;
    pmod = 2'b10;
    run(3);
    rst = 1'b0;
    run(5);
    check("held_rst_before_press", 2'b00, 3'b000, 1'b0);
    run(1);
    check("held_rst_single_press", 2'b01, 3'b000, 1'b0);   // E4
    pmod = 2'b11;
    run(10);
    check("held_rst_step_E4+10", 2'b01, 3'b001, 1'b0);

    // Pause landing on a tick wrap: the step is kept, then frozen
    pmod = 2'b10;
    run(5);
    check("wrap_pause_before", 2'b01, 3'b001, 1'b0);
    run(1);
    check("wrap_pause_step_kept", 2'b10, 3'b010, 1'b0);   // E4+16
    pmod = 2'b11;
    run(8);
    check("wrap_pause_hold", 2'b10, 3'b010, 1'b0);
    pmod = 2'b10;
    run(6);
    check("wrap_resume", 2'b01, 3'b010, 1'b0);            // R, tick frozen at 0

    // Stop landing on a tick wrap: the step is discarded
    pmod = 2'b11;
    run(2);
    pmod = 2'b01;
    run(5);
    check("wrap_stop_before", 2'b01, 3'b010, 1'b0);       // R+7
    run(1);
    check("wrap_stop_discard", 2'b00, 3'b000, 1'b0);      // R+8
    pmod = 2'b11;
    run(8);
    check("wrap_stop_settle", 2'b00, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
